// File: rtl/alu_rf_exec_pkg.sv
// Shared definitions for the ALU execution sequencer: widths, ALUop codes, flag bit positions, FSM states.
// Optional feature macro used by the top: STICKY_OVF_EN.
package alu_rf_exec_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b110;
   localparam logic [2:0] ALUOP_SLT = 3'b111;

   // Flag vector from the ALU is {Zero, CarryOut, Overflow}
   localparam int FLAG_OVF   = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_ZERO  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == ALUOP_AND) || (op == ALUOP_OR) || (op == ALUOP_ADD) ||
             (op == ALUOP_SUB) || (op == ALUOP_SLT);
   endfunction

endpackage

// File: rtl/alu_rf_exec_reg_file.sv
// Register file: one write port, three combinational read ports (rs, rt, debug).
// Register 0 always reads zero; synchronous reset clears every entry.
module alu_rf_exec_reg_file
   import alu_rf_exec_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic [DATA_WIDTH-1:0] rt_data,
   output logic [DATA_WIDTH-1:0] dbg_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NUM_RD = 3;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] raddr [NUM_RD];
   logic [DATA_WIDTH-1:0] rdata [NUM_RD];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign raddr[0] = rs_addr;
   assign raddr[1] = rt_addr;
   assign raddr[2] = dbg_addr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         assign rdata[gi] = (raddr[gi] == '0) ? '0 : mem[raddr[gi]];
      end
   endgenerate

   assign rs_data  = rdata[0];
   assign rt_data  = rdata[1];
   assign dbg_data = rdata[2];

endmodule

// File: rtl/alu_rf_exec.sv
// Execution sequencer: accepts reg-reg ops, feeds operands to an external ALU and writes the result back.
// Define STICKY_OVF_EN to add the sticky overflow indicator (ports ovf_clear / sticky_ovf).
module alu_rf_exec
   import alu_rf_exec_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [ADDR_WIDTH-1:0] in_rs,
   input  logic [ADDR_WIDTH-1:0] in_rt,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [2:0]            alu_flag,
   output logic                  wb_valid,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [2:0]            wb_flag,
   output logic                  op_err,
`ifdef STICKY_OVF_EN
   input  logic                  ovf_clear,
   output logic                  sticky_ovf,
`endif
   input  logic [ADDR_WIDTH-1:0] dbg_raddr,
   output logic [DATA_WIDTH-1:0] dbg_rdata
);

   state_t                state_reg;
   logic [2:0]            op_reg;
   logic [ADDR_WIDTH-1:0] rd_reg;
   logic [ADDR_WIDTH-1:0] rs_reg;
   logic [ADDR_WIDTH-1:0] rt_reg;
   logic [DATA_WIDTH-1:0] res_reg;
   logic [2:0]            flag_reg;
   logic                  err_reg;
   logic                  wb_valid_reg;
   logic [DATA_WIDTH-1:0] rs_data;
   logic [DATA_WIDTH-1:0] rt_data;
   logic                  rf_we;

   alu_rf_exec_reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rd_reg),
      .wdata    (res_reg),
      .rs_addr  (rs_reg),
      .rt_addr  (rt_reg),
      .dbg_addr (dbg_raddr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .dbg_data (dbg_rdata)
   );

   // The result lands in the register file on the edge that leaves WB
   assign rf_we = (state_reg == ST_WB) && !err_reg && (rd_reg != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         op_reg       <= '0;
         rd_reg       <= '0;
         rs_reg       <= '0;
         rt_reg       <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         res_reg      <= '0;
         flag_reg     <= '0;
         err_reg      <= 1'b0;
         wb_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  op_reg    <= in_op;
                  rd_reg    <= in_rd;
                  rs_reg    <= in_rs;
                  rt_reg    <= in_rt;
                  state_reg <= ST_READ;
               end
            end
            ST_READ: begin
               alu_a     <= rs_data;
               alu_b     <= rt_data;
               alu_op    <= op_reg;
               state_reg <= ST_EXEC;
            end
            ST_EXEC: begin
               // Illegal ops still drive the ALU but report zeros and skip the write
               res_reg      <= is_legal_op(alu_op) ? alu_result : '0;
               flag_reg     <= is_legal_op(alu_op) ? alu_flag : '0;
               err_reg      <= !is_legal_op(alu_op);
               wb_valid_reg <= 1'b1;
               state_reg    <= ST_WB;
            end
            default: begin
               res_reg      <= '0;
               flag_reg     <= '0;
               err_reg      <= 1'b0;
               wb_valid_reg <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_reg == ST_IDLE);
   assign wb_valid = wb_valid_reg && !rst;
   assign op_err   = err_reg && !rst;
   assign wb_addr  = wb_valid_reg ? rd_reg : '0;
   assign wb_data  = res_reg;
   assign wb_flag  = flag_reg;

`ifdef STICKY_OVF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
      end else if ((state_reg == ST_EXEC) && is_legal_op(alu_op) && alu_flag[FLAG_OVF]) begin
         sticky_ovf <= 1'b1;
      end else if (ovf_clear) begin
         sticky_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_rf_exec.sv
// Directed bench for alu_rf_exec with a behavioural ALU attached to the operand/result ports.
// Build with +define+STICKY_OVF_EN to also exercise the sticky overflow indicator.
module tb_alu_rf_exec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = '0;
   logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;
   logic [2:0]  alu_flag;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [2:0]  wb_flag;
   logic        op_err;
   logic [4:0]  dbg_raddr = '0;
   logic [31:0] dbg_rdata;
`ifdef STICKY_OVF_EN
   logic        ovf_clear = 1'b0;
   logic        sticky_ovf;
`endif

   int checks = 0;
   int errors = 0;

   // Lets the bench make the ALU return an arbitrary constant, used to load registers
   logic        force_en = 1'b0;
   logic [31:0] force_val = '0;

   always #5 clk = ~clk;

   alu_rf_exec dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_flag   (alu_flag),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_flag    (wb_flag),
      .op_err     (op_err),
`ifdef STICKY_OVF_EN
      .ovf_clear  (ovf_clear),
      .sticky_ovf (sticky_ovf),
`endif
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata)
   );

   // Behavioural ALU: Zero, CarryOut (borrow for SUB), Overflow
   always_comb begin
      logic [32:0] wide;
      logic        c, v;
      wide = '0;
      c = 1'b0;
      v = 1'b0;
      case (alu_op)
         3'b000: wide = {1'b0, alu_a & alu_b};
         3'b001: wide = {1'b0, alu_a | alu_b};
         3'b010: begin
            wide = {1'b0, alu_a} + {1'b0, alu_b};
            c = wide[32];
            v = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
         end
         3'b110: begin
            wide = {1'b0, alu_a - alu_b};
            c = (alu_a < alu_b);
            v = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
         end
         3'b111: wide = {32'd0, ($signed(alu_a) < $signed(alu_b))};
         default: wide = {1'b0, alu_a ^ alu_b};
      endcase
      if (force_en) begin
         alu_result = force_val;
         alu_flag   = {force_val == 32'd0, 2'b00};
      end else begin
         alu_result = wide[31:0];
         alu_flag   = {wide[31:0] == 32'd0, c, v};
      end
   end

   // Issues one op, returns edges from accept to wb_valid (-1 on timeout) and the WB outputs
   task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, output int lat, output logic [31:0] data,
                        output logic [2:0] flag, output logic err, output logic [4:0] addr);
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; data = 'x; flag = 'x; err = 1'bx; addr = 'x;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (wb_valid === 1'b1) begin
            lat = i; data = wb_data; flag = wb_flag; err = op_err; addr = wb_addr;
            break;
         end
      end
      @(posedge clk); #1;
      $display("txn op=%b rd=%0d rs=%0d rt=%0d lat=%0d data=%h flag=%b err=%b",
               op, rd, rs, rt, lat, data, flag, err);
   endtask

   task automatic read_dbg(input logic [4:0] a, output logic [31:0] d);
      dbg_raddr = a;
      #1;
      d = dbg_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err got %b exp 0", op_err); end
      checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
         errors++; $display("FAIL reset_alu_outs got %h %h %b exp 0", alu_a, alu_b, alu_op); end
      for (int a = 0; a < 32; a++) begin
         read_dbg(5'(a), d);
         checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rf[%0d] got %h exp 0", a, d); end
      end
   endtask

   task automatic test_seed();
      int lat; logic [31:0] data, d; logic [2:0] flag; logic err; logic [4:0] addr;
      issue(3'b010, 5'd1, 5'd0, 5'd0, lat, data, flag, err, addr);
      checks++; if (data !== 32'd0 || flag !== 3'b100) begin
         errors++; $display("FAIL seed_zero got %h/%b exp 0/100", data, flag); end
      force_en = 1'b1; force_val = 32'd5;
      issue(3'b010, 5'd1, 5'd0, 5'd0, lat, data, flag, err, addr);
      force_val = 32'd3;
      issue(3'b010, 5'd2, 5'd0, 5'd0, lat, data, flag, err, addr);
      force_en = 1'b0;
      read_dbg(5'd1, d);
      checks++; if (d !== 32'd5) begin errors++; $display("FAIL seed_r1 got %h exp 5", d); end
      read_dbg(5'd2, d);
      checks++; if (d !== 32'd3) begin errors++; $display("FAIL seed_r2 got %h exp 3", d); end
   endtask

   task automatic test_sub();
      int lat; logic [31:0] data, d; logic [2:0] flag; logic err; logic [4:0] addr;
      issue(3'b110, 5'd3, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sub_latency got %0d exp 2", lat); end
      checks++; if (data !== 32'd2) begin errors++; $display("FAIL sub_data got %h exp 2", data); end
      checks++; if (flag !== 3'b000) begin errors++; $display("FAIL sub_flag got %b exp 000", flag); end
      checks++; if (addr !== 5'd3 || err !== 1'b0) begin
         errors++; $display("FAIL sub_addr_err got %0d/%b exp 3/0", addr, err); end
      checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b110) begin
         errors++; $display("FAIL sub_alu_drive got %h %h %b exp 5 3 110", alu_a, alu_b, alu_op); end
      read_dbg(5'd3, d);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL sub_r3 got %h exp 2", d); end
   endtask

   task automatic test_slt();
      int lat; logic [31:0] data; logic [2:0] flag; logic err; logic [4:0] addr;
      issue(3'b111, 5'd4, 5'd2, 5'd1, lat, data, flag, err, addr);
      checks++; if (data !== 32'd1 || flag !== 3'b000) begin
         errors++; $display("FAIL slt_true got %h/%b exp 1/000", data, flag); end
      issue(3'b111, 5'd4, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (data !== 32'd0 || flag !== 3'b100) begin
         errors++; $display("FAIL slt_false got %h/%b exp 0/100", data, flag); end
   endtask

   task automatic test_r0_and_illegal();
      int lat; logic [31:0] data, d; logic [2:0] flag; logic err; logic [4:0] addr;
      issue(3'b010, 5'd0, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (lat !== 2 || err !== 1'b0 || addr !== 5'd0) begin
         errors++; $display("FAIL r0_wb got lat %0d err %b addr %0d exp 2 0 0", lat, err, addr); end
      checks++; if (data !== 32'd8) begin errors++; $display("FAIL r0_data got %h exp 8", data); end
      read_dbg(5'd0, d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL r0_read got %h exp 0", d); end
      issue(3'b011, 5'd3, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (err !== 1'b1 || lat !== 2) begin
         errors++; $display("FAIL illegal_err got %b lat %0d exp 1 2", err, lat); end
      checks++; if (data !== 32'd0 || flag !== 3'b000) begin
         errors++; $display("FAIL illegal_data got %h/%b exp 0/000", data, flag); end
      read_dbg(5'd3, d);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL illegal_target got %h exp 2", d); end
      checks++; if (op_err !== 1'b0 || wb_valid !== 1'b0) begin
         errors++; $display("FAIL pulse_width got %b/%b exp 0/0", op_err, wb_valid); end
   endtask

   task automatic test_src_eq_dst();
      int lat; logic [31:0] data, d; logic [2:0] flag; logic err; logic [4:0] addr;
      issue(3'b110, 5'd1, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (data !== 32'd2) begin errors++; $display("FAIL rs_eq_rd_data got %h exp 2", data); end
      read_dbg(5'd1, d);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL rs_eq_rd_r1 got %h exp 2", d); end
   endtask

   task automatic test_overflow();
      int lat; logic [31:0] data, d; logic [2:0] flag; logic err; logic [4:0] addr;
`ifdef STICKY_OVF_EN
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_pre got %b exp 0", sticky_ovf); end
`endif
      force_en = 1'b1; force_val = 32'h7FFF_FFFF;
      issue(3'b010, 5'd5, 5'd0, 5'd0, lat, data, flag, err, addr);
      force_en = 1'b0;
      issue(3'b010, 5'd6, 5'd5, 5'd5, lat, data, flag, err, addr);
      checks++; if (data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ovf_data got %h exp fffffffe", data); end
      checks++; if (flag !== 3'b001) begin errors++; $display("FAIL ovf_flag got %b exp 001", flag); end
      read_dbg(5'd6, d);
      checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ovf_r6 got %h exp fffffffe", d); end
`ifdef STICKY_OVF_EN
      checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set got %b exp 1", sticky_ovf); end
      issue(3'b000, 5'd7, 5'd1, 5'd2, lat, data, flag, err, addr);
      checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_hold got %b exp 1", sticky_ovf); end
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b exp 0", sticky_ovf); end
`endif
   endtask

   task automatic test_back_to_back();
      int accepts, wbs, first, second;
      logic [31:0] d;
      accepts = 0; wbs = 0; first = -1; second = -1;
      in_valid = 1'b1; in_op = 3'b000; in_rd = 5'd7; in_rs = 5'd1; in_rt = 5'd2;
      for (int i = 0; i < 16; i++) begin
         if (in_ready === 1'b1) begin
            if (accepts == 0) first = i;
            else if (accepts == 1) second = i;
            accepts++;
         end
         if (wb_valid === 1'b1) wbs++;
         if (i < 15) begin @(posedge clk); #1; end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      $display("txn back_to_back accepts=%0d wbs=%0d first=%0d second=%0d", accepts, wbs, first, second);
      checks++; if (accepts !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", accepts); end
      checks++; if (wbs !== 4) begin errors++; $display("FAIL b2b_wbs got %0d exp 4", wbs); end
      checks++; if (second - first !== 4) begin errors++; $display("FAIL b2b_spacing got %0d exp 4", second - first); end
      read_dbg(5'd7, d);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_r7 got %h exp 2", d); end
   endtask

   task automatic test_reset_in_exec();
      int seen;
      logic [31:0] d;
      in_valid = 1'b1; in_op = 3'b010; in_rd = 5'd8; in_rs = 5'd1; in_rt = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_exec_state got wb %b rdy %b exp 0 1", wb_valid, in_ready); end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (wb_valid === 1'b1) seen++;
      end
      $display("txn reset_in_exec wb_pulses=%0d", seen);
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_exec_wb got %0d pulses exp 0", seen); end
      for (int a = 0; a < 32; a++) begin
         read_dbg(5'(a), d);
         checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_exec_rf[%0d] got %h exp 0", a, d); end
      end
   endtask

   initial begin
      test_reset();
      test_seed();
      test_sub();
      test_slt();
      test_r0_and_illegal();
      test_src_eq_dst();
      test_overflow();
      test_back_to_back();
      test_reset_in_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
